// File: rtl/fetch_stage.sv
// Instruction-fetch stage.
//
// Owns the program counter, issues req/ack fetches to instruction memory and
// loads the IF/ID pipeline register with {pc+4, instruction}. Honours a stall
// from the hazard unit and a taken-branch redirect from EX/MEM. A redirect that
// arrives while a fetch is still outstanding waits for that fetch to complete,
// throws its data away and then continues at the redirect target.
//
// Ports
//   clk, rst       clock; synchronous active-high reset
//   stall          hold PC and IF/ID
//   pc_src         branch/jump taken: redirect to branch_target and flush IF/ID
//   branch_target  redirect address (low two bits ignored)
//   imem_req       fetch request (low only during the boot cycle)
//   imem_addr      fetch address (current PC)
//   imem_ack       instruction memory returns imem_data this cycle
//   imem_data      fetched instruction word
//   ifid_pc4       IF/ID: fetched address + 4
//   ifid_instr     IF/ID: fetched instruction
//   ifid_valid     IF/ID holds a real instruction (0 = bubble)
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        pc_src,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic [31:0] ifid_pc4,
    output logic [31:0] ifid_instr,
    output logic        ifid_valid
);

    typedef enum logic [1:0] {
        StBoot  = 2'b00,
        StFetch = 2'b01,
        StDrop  = 2'b10
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] redir_q, redir_d;
    logic [31:0] pc4_q, pc4_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;

    logic [31:0] target;
    logic [31:0] pc_plus4;

    assign target   = {branch_target[31:2], 2'b00};
    assign pc_plus4 = pc_q + 32'd4;   // wraps 32'hFFFF_FFFC -> 0

    assign imem_req   = (state_q != StBoot);
    assign imem_addr  = pc_q;
    assign ifid_pc4   = pc4_q;
    assign ifid_instr = instr_q;
    assign ifid_valid = valid_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        redir_d = redir_q;
        pc4_d   = pc4_q;
        instr_d = instr_q;
        valid_d = valid_q;

        case (state_q)
            StBoot: begin
                state_d = StFetch;
            end

            StFetch: begin
                if (pc_src) begin
                    pc4_d   = 32'd0;
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                    if (imem_ack) begin
                        pc_d = target;
                    end else begin
                        // Request for the old PC is in flight; it must finish first.
                        redir_d = target;
                        state_d = StDrop;
                    end
                end else if (stall) begin
                    // Any acked data is dropped; the same address is fetched again.
                end else if (imem_ack) begin
                    pc4_d   = pc_plus4;
                    instr_d = imem_data;
                    valid_d = 1'b1;
                    pc_d    = pc_plus4;
                end else begin
                    pc4_d   = 32'd0;
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end
            end

            StDrop: begin
                pc4_d   = 32'd0;
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
                if (pc_src) begin
                    redir_d = target;
                end
                if (imem_ack) begin
                    pc_d    = pc_src ? target : redir_q;
                    state_d = StFetch;
                end
            end

            default: begin
                state_d = StBoot;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StBoot;
            pc_q    <= RESET_PC;
            redir_q <= 32'd0;
            pc4_q   <= 32'd0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            redir_q <= redir_d;
            pc4_q   <= pc4_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

endmodule
